adc_capture_buf: RTL and testbench
==================================

Name: adc_capture_buf

Overview:
Parametrised successor to the single-channel ADC capture block. It samples CH_NUM ADC channels at a programmable rate set by a phase accumulator, with a default of 1.024 MHz from a 50 MHz sys_clk. Each channel's frame of DEPTH samples is stored in on-chip RAM, and fft_flag pulses when the frame is complete. The stored frames are then streamed channel by channel to the downstream FFT over a valid/ready interface.

Parameters:
DATA_W, 12, ADC sample width per channel.
DEPTH, 1024, samples per channel per frame; must be a power of 2, at least 4.
CH_NUM, 2, number of ADC channels, 1..8.
ACC_W, 32, phase accumulator width.
PHASE_INC, 87960930, accumulator increment; sample rate = f_clk*PHASE_INC/2^ACC_W (about 1.024 MHz at 50 MHz).

Ports:
sys_clk  in  1  system clock, 50 MHz.
sys_rst  in  1  reset; asynchronous, active-high.
start  in  1  one-cycle request to begin a capture frame.
adc_data  in  CH_NUM*DATA_W  ADC samples, offset binary; channel c occupies bits [c*DATA_W +: DATA_W].
adc_clk  out  1  sample clock to the ADC; equals the accumulator MSB.
busy  out  1  high in CAPTURE and READOUT.
fft_flag  out  1  one-cycle pulse when the last sample of the frame is written.
out_valid  out  1  output sample valid.
out_ready  in  1  downstream accept.
out_data  out  DATA_W  output sample.
out_ch  out  clog2(max(CH_NUM,2))  channel index of out_data.
out_last  out  1  high with the sample at index DEPTH-1 of each channel.

Behaviour:
- Reset state: all outputs 0, accumulator 0, state IDLE, all counters 0. RAM contents are not reset.
- Reset asserted mid-operation: immediate return to IDLE; no fft_flag; out_valid drops at once.
- FSM states: IDLE, CAPTURE, READOUT.
- IDLE -> CAPTURE: on start. Accumulator and write index clear on the same edge; busy=1 from the next cycle.
- start while busy: ignored.
- Sample strobe: the carry-out of acc+PHASE_INC, evaluated only in CAPTURE.
  - The accumulator free-runs in every state; it is cleared only on an accepted start.
  - First strobe is on the k-th cycle after start, where k = ceil(2^ACC_W/PHASE_INC). This is 49 at the default.
- On each strobe, every channel's adc_data slice is written to RAM at address {c, wr_idx}. The write is visible the next cycle. wr_idx then increments.
- CAPTURE -> READOUT: on the strobe that writes wr_idx = DEPTH-1. fft_flag=1 on the following cycle, for exactly 1 cycle.
- Strobes in READOUT or IDLE: ignored; nothing is written.
- READOUT order: channel 0 samples 0..DEPTH-1, then channel 1, and so on.
  - RAM read latency is 1 cycle. out_valid first rises 2 cycles after fft_flag.
  - out_data, out_ch and out_last are registered and hold stable while out_valid && !out_ready.
  - A transfer occurs when out_valid && out_ready.
  - With out_ready held high, one sample is delivered per cycle with no bubbles. A prefetch/skid register is required to achieve this.
  - out_valid never drops once raised until the final transfer.
- READOUT -> IDLE: on the transfer of channel CH_NUM-1, sample DEPTH-1. out_valid=0 and busy=0 on the next cycle.
- A start arriving on the same cycle as the final transfer is ignored. A start one cycle later is accepted.
- Index arithmetic: wr_idx and rd_idx are clog2(DEPTH) bits and wrap to 0 at DEPTH. The channel counter advances on each wrap.

Optional Feature:
Macro ADC_SIGNED_EN.
- Defined: out_data is two's complement, formed by inverting the MSB of the stored offset-binary sample (0x000 -> 0x800, 0x800 -> 0x000, 0xFFF -> 0x7FF).
- Undefined: out_data is the raw unsigned ADC code.
- Conversion is applied at the output register only and adds no latency.

Test Plan (DEPTH=8, CH_NUM=2, DATA_W=12, ACC_W=32, PHASE_INC=2^30):
1. Reset then idle: out_valid, fft_flag, busy and adc_clk all 0; assert start while sys_rst=1 -> no change.
2. Pulse start; drive ch0 = 0x100+n and ch1 = 0x200+n on strobe n -> strobe every 4 cycles with the first on cycle 4; fft_flag one pulse 1 cycle after strobe 7; busy high throughout.
3. out_ready=1 after scenario 2 -> 16 consecutive transfers: ch0 0x100..0x107 then ch1 0x200..0x207; out_last at beats 8 and 16; then busy=0.
4. out_ready toggled 1,0,0,1,... -> identical data sequence; out_data and out_ch stable during stalls; no drops or duplicates.
5. Pulse start during CAPTURE and during READOUT -> ignored, frame unchanged. Assert sys_rst at beat 5 of readout -> immediate IDLE; a new start captures a fresh frame correctly.
6. ADC_SIGNED_EN defined, ch0 samples 0x000, 0x800, 0xFFF -> out_data 0x800, 0x000, 0x7FF.

Source files
------------

// File: rtl/adc_capture_buf.sv
// adc_capture_buf: multi-channel ADC frame capture with valid/ready readout.
// Optional macro ADC_SIGNED_EN: emit two's complement samples (MSB inverted).
module adc_capture_buf #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 1024,
  parameter int CH_NUM = 2,
  parameter int ACC_W  = 32,
  parameter logic [ACC_W-1:0] PHASE_INC = ACC_W'(87960930)
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       start,
  input  logic [CH_NUM*DATA_W-1:0]   adc_data,
  output logic                       adc_clk,
  output logic                       busy,
  output logic                       fft_flag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2((CH_NUM > 1) ? CH_NUM : 2)-1:0] out_ch,
  output logic                       out_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2((CH_NUM > 1) ? CH_NUM : 2);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(CH_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_READOUT
  } state_e;

  state_e state_q, state_d;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;
  logic             carry;
  logic [AW-1:0]    wr_idx_q;
  logic             fft_q;

  logic [DATA_W-1:0] mem_q [CH_NUM][DEPTH];

  logic [AW-1:0]     rd_idx_q;
  logic [CW-1:0]     rd_ch_q;
  logic              rd_done_q;
  logic              rp_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CW-1:0]     rch_q;
  logic              rlast_q;

  logic              ov_q, ov_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic [CW-1:0]     oc_q, oc_d;
  logic              ol_q, ol_d;
  logic              sv_q, sv_d;
  logic [DATA_W-1:0] sd_q, sd_d;
  logic [CW-1:0]     sc_q, sc_d;
  logic              sl_q, sl_d;

  logic       start_ok;
  logic       strobe;
  logic       wr_last;
  logic       xfer;
  logic       final_xfer;
  logic       issue;
  logic [1:0] occ;

  function automatic logic [DATA_W-1:0] conv(input logic [DATA_W-1:0] v);
`ifdef ADC_SIGNED_EN
    return {~v[DATA_W-1], v[DATA_W-2:0]};
`else
    return v;
`endif
  endfunction

  assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, PHASE_INC};
  assign start_ok   = start && (state_q == S_IDLE);
  assign strobe     = carry && (state_q == S_CAPTURE);
  assign wr_last    = (wr_idx_q == LAST_IDX);
  assign xfer       = ov_q && out_ready;
  assign final_xfer = xfer && ol_q && (oc_q == LAST_CH);
  assign occ        = {1'b0, ov_q} + {1'b0, sv_q} + {1'b0, rp_q};
  assign issue      = (state_q == S_READOUT) && !rd_done_q
                      && (occ <= ({1'b0, xfer} + 2'd1));

  assign adc_clk   = acc_q[ACC_W-1];
  assign busy      = (state_q != S_IDLE);
  assign fft_flag  = fft_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_ch    = oc_q;
  assign out_last  = ol_q;

  // Next-state logic for the capture/readout sequencer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_ok) state_d = S_CAPTURE;
      S_CAPTURE: if (strobe && wr_last) state_d = S_READOUT;
      S_READOUT: if (final_xfer) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State, phase accumulator, write index and frame-done pulse
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      wr_idx_q <= '0;
      fft_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= start_ok ? '0 : acc_sum;
      fft_q    <= strobe && wr_last;
      if (start_ok)
        wr_idx_q <= '0;
      else if (strobe)
        wr_idx_q <= wr_idx_q + 1'b1;
    end
  end

  // Sample RAM: all channels written per strobe, one read per issue
  always_ff @(posedge sys_clk) begin
    if (strobe) begin
      for (int c = 0; c < CH_NUM; c++)
        mem_q[c][wr_idx_q] <= adc_data[c*DATA_W +: DATA_W];
    end
    if (issue)
      rdata_q <= mem_q[rd_ch_q][rd_idx_q];
  end

  // Read address walk: channel-major, sample-minor
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_idx_q  <= '0;
      rd_ch_q   <= '0;
      rd_done_q <= 1'b0;
      rp_q      <= 1'b0;
      rch_q     <= '0;
      rlast_q   <= 1'b0;
    end else begin
      rp_q <= issue;
      if (start_ok) begin
        rd_idx_q  <= '0;
        rd_ch_q   <= '0;
        rd_done_q <= 1'b0;
      end else if (issue) begin
        rch_q    <= rd_ch_q;
        rlast_q  <= (rd_idx_q == LAST_IDX);
        rd_idx_q <= rd_idx_q + 1'b1;
        if (rd_idx_q == LAST_IDX) begin
          if (rd_ch_q == LAST_CH)
            rd_done_q <= 1'b1;
          else
            rd_ch_q <= rd_ch_q + 1'b1;
        end
      end
    end
  end

  // Output register fed from skid first, then from the RAM read
  always_comb begin
    ov_d = ov_q;
    od_d = od_q;
    oc_d = oc_q;
    ol_d = ol_q;
    sv_d = sv_q;
    sd_d = sd_q;
    sc_d = sc_q;
    sl_d = sl_q;
    if (!ov_q || xfer) begin
      if (sv_q) begin
        ov_d = 1'b1;
        od_d = conv(sd_q);
        oc_d = sc_q;
        ol_d = sl_q;
        sv_d = rp_q;
        sd_d = rdata_q;
        sc_d = rch_q;
        sl_d = rlast_q;
      end else if (rp_q) begin
        ov_d = 1'b1;
        od_d = conv(rdata_q);
        oc_d = rch_q;
        ol_d = rlast_q;
      end else begin
        ov_d = 1'b0;
      end
    end else if (rp_q) begin
      sv_d = 1'b1;
      sd_d = rdata_q;
      sc_d = rch_q;
      sl_d = rlast_q;
    end
  end

  // Output and skid registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ov_q <= 1'b0;
      od_q <= '0;
      oc_q <= '0;
      ol_q <= 1'b0;
      sv_q <= 1'b0;
      sd_q <= '0;
      sc_q <= '0;
      sl_q <= 1'b0;
    end else begin
      ov_q <= ov_d;
      od_q <= od_d;
      oc_q <= oc_d;
      ol_q <= ol_d;
      sv_q <= sv_d;
      sd_q <= sd_d;
      sc_q <= sc_d;
      sl_q <= sl_d;
    end
  end

endmodule

// File: tb/tb_adc_capture_buf.sv
// tb_adc_capture_buf: directed bench for adc_capture_buf.
// DEPTH=8, CH_NUM=2, PHASE_INC=2^30 -> one strobe every 4 cycles.
module tb_adc_capture_buf;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] adc_data = '0;
  logic        adc_clk;
  logic        busy;
  logic        fft_flag;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_data;
  logic [0:0]  out_ch;
  logic        out_last;

  int checks = 0;
  int errors = 0;
  logic [11:0] ch0v [8];
  logic [11:0] ch1v [8];

  adc_capture_buf #(
    .DATA_W(12), .DEPTH(8), .CH_NUM(2), .ACC_W(32),
    .PHASE_INC(32'h4000_0000)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .adc_data(adc_data), .adc_clk(adc_clk), .busy(busy),
    .fft_flag(fft_flag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_data(input int b);
    logic [11:0] v;
    v = (b < 8) ? ch0v[b] : ch1v[b-8];
`ifdef ADC_SIGNED_EN
    v[11] = ~v[11];
`endif
    return v;
  endfunction

  task automatic set_frame(input logic [11:0] b0, input logic [11:0] b1);
    for (int n = 0; n < 8; n++) begin
      ch0v[n] = b0 + 12'(n);
      ch1v[n] = b1 + 12'(n);
    end
  endtask

  // start pulse, then cycles 1..34; strobe n lands on cycle 4(n+1)
  task automatic capture(input int extra);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      n = (c - 1) / 4;
      if (n > 7) n = 7;
      adc_data = {ch1v[n], ch0v[n]};
      start = (c == extra);
      chk("cap_busy", busy, 1);
      chk("cap_fft", fft_flag, (c == 33));
      chk("cap_adcclk", adc_clk, (((c - 1) % 4) >= 2));
      chk("cap_ovld", out_valid, 0);
      tick();
    end
    start = 1'b0;
  endtask

  // mode 0: ready high; mode 1: ready 1,0,0,1 repeating
  task automatic readout(input int mode, input int rst_beat,
                         input int start_beat, input bit fin_start);
    int  beat = 0;
    int  cyc  = 0;
    logic rdy;
    while (beat < 16 && cyc < 200) begin
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      out_ready = rdy;
      if (beat == rst_beat) begin
        sys_rst = 1'b1;
        #1;
        chk("rst_ovld", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fft", fft_flag, 0);
        #2;
        sys_rst = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("rst_idle", busy, 0);
        return;
      end
      start = (beat == start_beat) || (fin_start && beat == 15 && rdy);
      chk("rd_valid", out_valid, 1);
      chk("rd_busy", busy, 1);
      chk("rd_data", out_data, exp_data(beat));
      chk("rd_ch", out_ch, beat / 8);
      chk("rd_last", out_last, (beat % 8 == 7));
      if (rdy) beat++;
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("rd_beats", beat, 16);
    chk("end_ovld", out_valid, 0);
    chk("end_busy", busy, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    // reset, and start held while reset is high
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fft_flag", fft_flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_adc_clk", adc_clk, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    start = 1'b1;
    tick();
    tick();
    chk("rst_start_busy", busy, 0);
    chk("rst_start_clk", adc_clk, 0);
    start = 1'b0;
    sys_rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_ovld", out_valid, 0);

    // capture with start during capture; start during readout and at final beat
    set_frame(12'h100, 12'h200);
    capture(10);
    readout(0, -1, 3, 1'b1);

    // start one cycle after final transfer; stalled readout
    capture(-1);
    readout(1, -1, -1, 1'b0);

    // reset during readout, then a fresh frame
    set_frame(12'h300, 12'h400);
    capture(-1);
    readout(0, 5, -1, 1'b0);
    set_frame(12'h500, 12'h600);
    capture(-1);
    readout(1, -1, -1, 1'b0);

    // offset-binary boundary codes
    set_frame(12'h000, 12'hA00);
    ch0v[0] = 12'h000;
    ch0v[1] = 12'h800;
    ch0v[2] = 12'hFFF;
    ch0v[3] = 12'h7FF;
    capture(-1);
    readout(0, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
